// File: rtl/m65_bus_wait_gen_if.sv
// CPU bus cycle interface between the CPU/speed-controller side and the wait-state generator.
// master: drives the cycle request, phi0, cpu_ready and ext_ack; slave: returns ready/ext request.
// Pure wiring bundle: no logic, no latency.
interface m65_bus_wait_gen_if;
  logic        bus_valid;
  logic [27:0] bus_addr;
  logic        bus_write;
  logic        phi0;
  logic        cpu_ready;
  logic        ext_ack;
  logic        bus_ready;
  logic        ext_req;
  logic        ext_write;
  logic        bus_timeout;

  modport master (
    output bus_valid, bus_addr, bus_write, phi0, cpu_ready, ext_ack,
    input  bus_ready, ext_req, ext_write, bus_timeout
  );

  modport slave (
    input  bus_valid, bus_addr, bus_write, phi0, cpu_ready, ext_ack,
    output bus_ready, ext_req, ext_write, bus_timeout
  );
endinterface

// File: rtl/m65_bus_wait_gen.sv
// Wait-state generator: decodes each bus cycle into FAST/IO/SLOW/EXT and drives bus_ready.
// Latency: FAST 0, IO IO_WAIT clks, SLOW next phi0 rise + SLOW_HOLD+1 clks, EXT until ext_ack.
// Backpressure: once ready, bus_ready stays high until cpu_ready; optional BUS_TIMEOUT_EN bounds ext_ack.
module m65_bus_wait_gen #(
  parameter int IO_WAIT        = 1,
  parameter int SLOW_HOLD      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  m65_bus_wait_gen_if.slave        bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CNT, S_WAIT_PHI, S_HOLD, S_WAIT_ACK, S_DONE
  } state_t;

  typedef enum logic [1:0] {R_FAST, R_IO, R_SLOW, R_EXT} region_t;

  // Counter loads saturate at the 4-bit counter range.
  localparam logic [3:0] IO_LOAD    = 4'((IO_WAIT > 16) ? 15 : ((IO_WAIT > 0) ? IO_WAIT - 1 : 0));
  localparam logic [3:0] HOLD_LOAD  = 4'((SLOW_HOLD > 15) ? 15 : SLOW_HOLD);
  localparam bit         IO_NO_WAIT = (IO_WAIT == 0);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_write_q, ext_write_d;
  logic        phi0_q;
  logic        phi_rise;
  logic        accept;
  logic        bus_ready_c;
  region_t     region;

`ifdef BUS_TIMEOUT_EN
  localparam int         TO_CLAMP = (TIMEOUT_CYCLES > 255) ? 255 : ((TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES);
  localparam logic [7:0] TO_LAST  = 8'(TO_CLAMP - 1);
  logic [7:0]  tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign phi_rise = bus.phi0 & ~phi0_q;

  // Address decode; IO is carved out of the EXT half of the map.
  always_comb begin
    region = R_FAST;
    if (bus.bus_addr[27:12] == 16'hFFD3)     region = R_IO;
    else if (bus.bus_addr[27:26] == 2'b01)   region = R_SLOW;
    else if (bus.bus_addr[27])               region = R_EXT;
  end

  // Next-state and bus_ready; a new cycle is decoded identically from IDLE and from DONE+cpu_ready.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ext_req_d   = ext_req_q;
    ext_write_d = ext_write_q;
    bus_ready_c = 1'b0;
    accept      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        bus_ready_c = ~(bus.bus_valid & (region != R_FAST)) |
                      (IO_NO_WAIT & (region == R_IO));
        accept      = bus.bus_valid;
      end
      S_WAIT_CNT, S_HOLD: begin
        if (wcnt_q == 4'd0) state_d = S_DONE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_WAIT_PHI: begin
        if (phi_rise) begin
          wcnt_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_WAIT_ACK: begin
        if (bus.ext_ack) begin
          ext_req_d = 1'b0;
          state_d   = S_DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tcnt_q == TO_LAST) begin
          ext_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        bus_ready_c = 1'b1;
        if (bus.cpu_ready) begin
          state_d = S_IDLE;
          accept  = bus.bus_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      case (region)
        R_IO: begin
          if (!IO_NO_WAIT) begin
            wcnt_d  = IO_LOAD;
            state_d = S_WAIT_CNT;
          end else begin
            state_d = S_IDLE;
          end
        end
        R_SLOW: state_d = S_WAIT_PHI;
        R_EXT: begin
          ext_req_d   = 1'b1;
          ext_write_d = bus.bus_write;
          state_d     = S_WAIT_ACK;
`ifdef BUS_TIMEOUT_EN
          tcnt_d      = 8'd0;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      ext_req_q   <= 1'b0;
      ext_write_q <= 1'b0;
      phi0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ext_req_q   <= ext_req_d;
      ext_write_q <= ext_write_d;
      phi0_q      <= bus.phi0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // ext_ack watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.bus_timeout = timeout_q;
`else
  assign bus.bus_timeout = 1'b0;
`endif

  assign bus.bus_ready = bus_ready_c;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_write = ext_write_q;

endmodule

// File: tb/tb_m65_bus_wait_gen.sv
// Testbench for m65_bus_wait_gen: decode vector table plus multi-cycle IO/SLOW/EXT/back-to-back/reset sequences.
// Build with BUS_TIMEOUT_EN defined to also exercise the ext_ack timeout path.
module tb_m65_bus_wait_gen;

  localparam int IO_WAIT   = 3;
  localparam int SLOW_HOLD = 2;
  localparam int TO_CYC    = 10;
`ifdef BUS_TIMEOUT_EN
  localparam int EXT_WAIT  = 5;
`else
  localparam int EXT_WAIT  = 11;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  m65_bus_wait_gen_if bus ();

  m65_bus_wait_gen #(
    .IO_WAIT        (IO_WAIT),
    .SLOW_HOLD      (SLOW_HOLD),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [27:0] addr;
    logic        exp_rdy_now;
    logic        exp_rdy_next;
    logic        exp_req_next;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.bus_valid = 1'b0;
    bus.ext_ack   = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.phi0      = 1'b0;
    bus.bus_write = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Counts consecutive low bus_ready samples (current one included), bounded by limit.
  task automatic count_low(input int limit, output int n);
    n = 0;
    while (bus.bus_ready !== 1'b1 && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic start_cycle(input logic [27:0] addr, input logic wr);
    bus.bus_addr  = addr;
    bus.bus_write = wr;
    bus.bus_valid = 1'b1;
  endtask

  initial begin
    int  n;
    logic bad;
    n_chk  = 0;
    n_fail = 0;
    reset         = 1'b1;
    bus.bus_valid = 1'b0;
    bus.bus_addr  = 28'h0;
    bus.bus_write = 1'b0;
    bus.phi0      = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.ext_ack   = 1'b0;

    vecs[0]  = '{1'b0, 28'h8000100, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 28'h0002000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 28'hFFD3020, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 28'h4000010, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 28'h8000100, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 28'hFFD2FFF, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 28'hFFD4000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 28'h3FFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 28'h7FFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 28'hFFD3FFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 28'hC000000, 1'b0, 1'b0, 1'b1};

    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_bus_ready",   32'(bus.bus_ready),   32'd1);
    chk("reset_ext_req",     32'(bus.ext_req),     32'd0);
    chk("reset_ext_write",   32'(bus.ext_write),   32'd0);
    chk("reset_bus_timeout", 32'(bus.bus_timeout), 32'd0);

    // Decode table: each vector starts from IDLE.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      bus.bus_addr  = vecs[i].addr;
      bus.bus_valid = vecs[i].valid;
      #1;
      chk($sformatf("vec%0d_rdy_now", i),  32'(bus.bus_ready), 32'(vecs[i].exp_rdy_now));
      tick();
      chk($sformatf("vec%0d_rdy_next", i), 32'(bus.bus_ready), 32'(vecs[i].exp_rdy_next));
      chk($sformatf("vec%0d_req_next", i), 32'(bus.ext_req),   32'(vecs[i].exp_req_next));
      bus.bus_valid = 1'b0;
    end

    // IO cycle: IO_WAIT low clocks, then held ready while cpu_ready stays low.
    do_reset();
    start_cycle(28'hFFD3020, 1'b0);
    tick();
    count_low(40, n);
    chk("io_low_clks", 32'(n), 32'(IO_WAIT));
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.bus_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    chk("io_hold_ready", 32'(bad), 32'd0);
    bus.cpu_ready = 1'b1;
    bus.bus_valid = 1'b0;
    tick();
    bus.cpu_ready = 1'b0;
    chk("io_idle_ready", 32'(bus.bus_ready), 32'd1);
    start_cycle(28'hFFD3020, 1'b0);
    #1;
    chk("io_idle_redecode", 32'(bus.bus_ready), 32'd0);
    bus.bus_valid = 1'b0;

    // SLOW cycle: phi0 rises 7 clks after accept, then SLOW_HOLD+1 low clocks.
    do_reset();
    start_cycle(28'h4000010, 1'b0);
    tick();
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.bus_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("slow_wait_phi", 32'(bad), 32'd0);
    bus.phi0 = 1'b1;
    tick();
    count_low(40, n);
    chk("slow_hold_clks", 32'(n), 32'(SLOW_HOLD + 1));
    bus.phi0 = 1'b0;

    // SLOW cycle whose phi0 edge coincides with acceptance: that edge is ignored.
    do_reset();
    start_cycle(28'h4000010, 1'b0);
    bus.phi0 = 1'b1;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.bus_ready !== 1'b0) bad = 1'b1;
      if (k == 1) bus.phi0 = 1'b0;
      tick();
    end
    chk("slow_accept_edge_ignored", 32'(bad), 32'd0);
    bus.phi0 = 1'b1;
    tick();
    count_low(40, n);
    chk("slow_second_edge", 32'(n), 32'(SLOW_HOLD + 1));
    bus.phi0 = 1'b0;

    // EXT write: ext_req/ext_write held until ext_ack, ack in IDLE ignored.
    do_reset();
    start_cycle(28'h8000100, 1'b1);
    tick();
    bad = 1'b0;
    for (int k = 0; k < EXT_WAIT; k++) begin
      if (bus.ext_req !== 1'b1 || bus.ext_write !== 1'b1 || bus.bus_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("ext_req_held", 32'(bad), 32'd0);
    bus.ext_ack = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    chk("ext_ack_req_drop", 32'(bus.ext_req),   32'd0);
    chk("ext_ack_ready",    32'(bus.bus_ready), 32'd1);
    bus.cpu_ready = 1'b1;
    bus.bus_valid = 1'b0;
    tick();
    bus.cpu_ready = 1'b0;
    bus.ext_ack   = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    chk("ext_idle_ack_req",   32'(bus.ext_req),   32'd0);
    chk("ext_idle_ack_ready", 32'(bus.bus_ready), 32'd1);

    // Back-to-back: new IO cycle accepted in DONE with no IDLE bubble.
    do_reset();
    start_cycle(28'hFFD3020, 1'b0);
    tick();
    count_low(40, n);
    chk("b2b_first_done", 32'(bus.bus_ready), 32'd1);
    bus.cpu_ready = 1'b1;
    bus.bus_addr  = 28'hFFD3040;
    #1;
    chk("b2b_done_ready", 32'(bus.bus_ready), 32'd1);
    tick();
    bus.cpu_ready = 1'b0;
    chk("b2b_no_bubble", 32'(bus.bus_ready), 32'd0);
    count_low(40, n);
    chk("b2b_low_clks", 32'(n), 32'(IO_WAIT));
    bus.cpu_ready = 1'b1;
    bus.bus_valid = 1'b0;
    tick();
    bus.cpu_ready = 1'b0;

    // Reset in WAIT_ACK, then a stale ext_ack.
    do_reset();
    start_cycle(28'h8000100, 1'b1);
    tick();
    chk("rst_ack_req_before", 32'(bus.ext_req), 32'd1);
    reset         = 1'b1;
    bus.bus_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_ack_req",   32'(bus.ext_req),   32'd0);
    chk("rst_ack_write", 32'(bus.ext_write), 32'd0);
    chk("rst_ack_ready", 32'(bus.bus_ready), 32'd1);
    bus.ext_ack = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    chk("rst_stale_ack", 32'(bus.ext_req), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // Timeout without ack: ext_req high for TO_CYC clks, sticky flag.
    do_reset();
    start_cycle(28'h8000100, 1'b0);
    tick();
    n = 0;
    while (bus.ext_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_clks", 32'(n),               32'(TO_CYC));
    chk("to_flag",     32'(bus.bus_timeout), 32'd1);
    chk("to_ready",    32'(bus.bus_ready),   32'd1);
    bus.cpu_ready = 1'b1;
    bus.bus_valid = 1'b0;
    tick();
    bus.cpu_ready = 1'b0;
    chk("to_sticky", 32'(bus.bus_timeout), 32'd1);

    // Ack coincident with the final timeout clock wins.
    do_reset();
    chk("to_reset_clear", 32'(bus.bus_timeout), 32'd0);
    start_cycle(28'h8000100, 1'b0);
    tick();
    for (int k = 0; k < TO_CYC - 1; k++) tick();
    chk("to_race_req_still", 32'(bus.ext_req), 32'd1);
    bus.ext_ack = 1'b1;
    tick();
    bus.ext_ack = 1'b0;
    chk("to_race_flag",  32'(bus.bus_timeout), 32'd0);
    chk("to_race_req",   32'(bus.ext_req),     32'd0);
    chk("to_race_ready", 32'(bus.bus_ready),   32'd1);
`else
    chk("no_timeout_flag", 32'(bus.bus_timeout), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m65_bus_wait_gen.md
Name: m65_bus_wait_gen

Overview:
Wait-state generator that sits directly upstream of the CPU speed controller and produces its bus_ready input. It decodes each CPU bus cycle's 28-bit address into one of four latency classes and holds bus_ready low until the cycle may finish. It then keeps bus_ready high until the speed controller's cpu_ready shows the CPU has consumed the cycle. Slow-bus cycles are aligned to rising edges of the exported phi0 clock.

Parameters:
IO_WAIT, 1, wait cycles for $FFD3xxx I/O accesses (0..15)
SLOW_HOLD, 2, clk cycles held after the phi0 rising edge for slow-bus accesses (0..15)
TIMEOUT_CYCLES, 255, ext_ack timeout in clk cycles (used only with the optional feature, 1..255)

Ports:
clk  in  1  system clock (CPU clock domain)
reset  in  1  synchronous, active-high reset
bus_valid  in  1  CPU presents a new bus cycle this clk
bus_addr  in  28  mapped address of the cycle
bus_write  in  1  cycle is a write (informational; latched)
phi0  in  1  1 MHz phase clock from the speed controller
cpu_ready  in  1  cycle-accept signal from the speed controller
ext_ack  in  1  external memory/expansion completion pulse
bus_ready  out  1  cycle may complete (to speed controller)
ext_req  out  1  request to external memory, held until ext_ack
ext_write  out  1  latched bus_write for the external request
bus_timeout  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Region decode on bus_addr:
  - IO: bus_addr[27:12]==16'hFFD3.
  - SLOW: bus_addr[27:26]==2'b01.
  - EXT: bus_addr[27]==1 and not IO.
  - FAST: everything else.
- States: IDLE, WAIT_CNT, WAIT_PHI, HOLD, WAIT_ACK, DONE.
- bus_ready is combinational from the state:
  - IDLE: bus_ready = ~(bus_valid & region!=FAST), or 1 when IO_WAIT==0 and the region is IO.
  - DONE: 1.
  - All other states: 0.
- IDLE, on bus_valid:
  - FAST: stay in IDLE; the cycle completes through cpu_ready with zero wait.
  - IO with IO_WAIT>0: load wcnt=IO_WAIT-1 and go to WAIT_CNT.
  - SLOW: go to WAIT_PHI.
  - EXT: set ext_req=1, latch ext_write=bus_write, go to WAIT_ACK.
- WAIT_CNT: decrement wcnt; at 0 go to DONE. Latency is exactly IO_WAIT cycles of bus_ready low.
- WAIT_PHI: phi0 is registered once (phi0_q). A rising edge is phi0 & ~phi0_q.
  - On an edge: load wcnt=SLOW_HOLD and go to HOLD.
  - An edge in the same cycle bus_valid is accepted does not count; wait for the next edge.
- HOLD: decrement wcnt; at 0 go to DONE. SLOW_HOLD==0 goes to DONE on the cycle after the edge.
- WAIT_ACK: on ext_ack, clear ext_req and go to DONE. ext_ack in any other state is ignored.
- DONE: remain until cpu_ready==1.
  - On cpu_ready with bus_valid low: go to IDLE.
  - On cpu_ready with bus_valid high in the same cycle: decode the new cycle exactly as from IDLE (back-to-back, no bubble).
- bus_valid in a non-IDLE/non-DONE state is ignored; the CPU holds it until ready.
- wcnt is 4 bits; loads are clamped to 15.
- Reset, including mid-cycle: state=IDLE, wcnt=0, ext_req=0, ext_write=0, bus_timeout=0, phi0_q=0. bus_ready is then 1 (with bus_valid low). A pending ext_ack arriving after reset is ignored.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to WAIT_ACK and counts every clk.
  - At TIMEOUT_CYCLES without ext_ack: clear ext_req, set bus_timeout=1 (sticky until reset), go to DONE.
  - If ext_ack and the timeout hit occur in the same cycle, ext_ack wins and the flag stays clear.
- Undefined: no counter; WAIT_ACK waits indefinitely; bus_timeout is tied 0.

Test Plan:
1. FAST: bus_valid, addr 28'h0002000, cpu_ready=1 -> bus_ready stays 1 in the same cycle; state remains IDLE.
2. IO: IO_WAIT=3, addr 28'hFFD3020 -> bus_ready low for exactly 3 clks, then high; it stays high while cpu_ready=0 for 5 clks and drops to IDLE behaviour after the cpu_ready pulse.
3. SLOW: addr 28'h4000010, first phi0 rise 7 clks later, SLOW_HOLD=2 -> bus_ready rises exactly 3 clks after the registered edge is detected.
4. EXT: addr 28'h8000100, write=1 -> ext_req=1 with ext_write=1 until the ext_ack pulse at clk 12; bus_ready=1 on the next clk; a second ext_ack while in IDLE has no effect.
5. Back-to-back: in DONE, cpu_ready=1 with a new bus_valid to IO (IO_WAIT=1) -> bus_ready 0 on the very next clk with no IDLE bubble; reset asserted in WAIT_ACK -> ext_req=0 and bus_ready=1 on the following clk.
6. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=10: no ext_ack -> ext_req drops and bus_timeout=1 after 10 clks; ack coincident with the 10th clk -> bus_timeout stays 0.
